lsu_bus_master: RTL and testbench

// - Load/store initiator between the MIPS datapath and a handshaked data-memory responder.
// - Decodes the opcode of Ins (LB/LBU/LH/LHU/LW/SB/SH/SW), builds byte enables and lane-steered write data.
// - Runs one bus transaction per request, then returns sign/zero-extended load data to the register write-back mux.
// - Stalls the pipeline via busy while a transaction is in flight.

---
 rtl/lsu_bus_master_pkg.sv | 67 ++++++
 rtl/lsu_bus_master_if.sv | 33 +++
 rtl/lsu_bus_master_lane_align.sv | 77 +++++++
 rtl/lsu_bus_master.sv | 150 +++++++++++++++
 tb/tb_lsu_bus_master.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_master_pkg.sv
// ----------------------------------------------------------------------------
// lsu_bus_master_pkg
// Shared definitions for the load/store bus master:
//   - MIPS load/store opcodes (Ins[31:26])
//   - FSM state encodings (plain 2-bit constants, legacy compatible)
//   - access-size decode and opcode classification helpers
// No ports (package).
// ----------------------------------------------------------------------------
package lsu_bus_master_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } lsu_size_e;

  function automatic lsu_size_e op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Only LB and LH sign-extend; the U variants and LW do not.
  function automatic logic is_signed_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op_size(op))
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// ----------------------------------------------------------------------------
// lsu_bus_master_if
// Handshaked data-memory bus between the LSU (master) and the memory
// responder (slave).
//   mem_req    master->slave  request valid
//   mem_we     master->slave  1 = store, 0 = load
//   mem_addr   master->slave  word-aligned byte address
//   mem_be     master->slave  byte enables, bit i = lane i
//   mem_wdata  master->slave  lane-steered store data
//   mem_ack    slave->master  accept/complete, read data valid same cycle
//   mem_rdata  slave->master  read data
// ----------------------------------------------------------------------------
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_bus_master_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane steering for the load/store unit.
//   op       in   6   load/store opcode
//   offset   in   2   byte offset Adr[1:0]
//   wdata    in   32  right-aligned store data
//   rdata    in   32  raw memory read word
//   be       out  4   byte enables (0 for non load/store opcodes)
//   wdata_o  out  32  store data replicated across the addressed lanes
//   ldata    out  32  selected lane, sign/zero-extended
// Low offset bits that do not fit the access size are ignored: halves use
// offset[1] only, words always use lane 0.
// ----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_bus_master_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata
);

  function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
    logic signed [31:0] r;
    r = b;
    return r;
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
    logic signed [31:0] r;
    r = h;
    return r;
  endfunction

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    lane_b = rdata[7:0];
    case (offset)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
  end

  always_comb begin
    be      = 4'b0000;
    wdata_o = wdata;
    ldata   = rdata;
    case (op_size(op))
      SZ_BYTE: begin
        be      = 4'b0001 << offset;
        wdata_o = {4{wdata[7:0]}};
        ldata   = is_signed_load(op) ? sext8(lane_b) : {24'h0, lane_b};
      end
      SZ_HALF: begin
        be      = 4'b0011 << {offset[1], 1'b0};
        wdata_o = {2{wdata[15:0]}};
        ldata   = is_signed_load(op) ? sext16(lane_h) : {16'h0, lane_h};
      end
      SZ_WORD: begin
        be      = 4'b1111;
        wdata_o = wdata;
        ldata   = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// ----------------------------------------------------------------------------
// lsu_bus_master
// Load/store initiator between the MIPS datapath and a handshaked memory
// responder. One bus transaction per accepted start; loads return
// sign/zero-extended data on Rdata with the done pulse.
//   CLK     in   1       clock
//   RST     in   1       asynchronous active-low reset
//   start   in   1       pulse: sample Ins/Adr/Wdata and begin
//   Ins     in   32      instruction, opcode Ins[31:26]
//   Adr     in   ADDR_W  effective byte address
//   Wdata   in   32      right-aligned store data
//   busy    out  1       transaction in flight (REQ/WAIT)
//   done    out  1       one-cycle completion pulse
//   err     out  1       valid with done: timeout (or misalign trap)
//   Rdata   out  32      extended load data, held until next load completes
//   bus     master modport of lsu_bus_master_if
// Parameters: TIMEOUT_CYC (2..255) WAIT cycles before bus error, ADDR_W.
// Build option: define LSU_MISALIGN_TRAP_EN to complete misaligned half/word
// accesses with err=1 and no bus request; otherwise the offending low address
// bits are ignored.
// ----------------------------------------------------------------------------
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [31:0]       Ins,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [31:0]       Wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       Rdata,
  lsu_bus_master_if.master  bus
);

  logic [1:0]        state, state_nx;
  logic [5:0]        op_r;
  logic [1:0]        off_r;
  logic [31:0]       wdata_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [7:0]        timer;
  logic              err_r;
  logic [31:0]       rdata_r;

  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] ldata_w;

  logic [5:0] start_op;
  logic       accept;
  logic       trap;
  logic       in_bus;
  logic       ack_ok;
  logic       expire;
  logic       unused_ins;

  assign start_op   = Ins[31:26];
  assign unused_ins = ^Ins[25:0];

  // FIN accepts a new start as well, giving back-to-back transactions.
  assign accept = start && ((state == ST_IDLE) || (state == ST_FIN)) && is_mem_op(start_op);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(start_op, Adr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign in_bus = (state == ST_REQ) || (state == ST_WAIT);
  assign ack_ok = in_bus && bus.mem_ack;
  // Ack in the expiry cycle takes priority, so expire requires no ack.
  assign expire = (state == ST_WAIT) && !bus.mem_ack &&
                  (timer == 8'(TIMEOUT_CYC - 1));

  // Steering is driven from the captured request so bus outputs stay stable
  // for the whole transaction regardless of what the datapath does.
  lsu_lane_align u_align (
    .op      (op_r),
    .offset  (off_r),
    .wdata   (wdata_r),
    .rdata   (bus.mem_rdata),
    .be      (be_w),
    .wdata_o (wdata_w),
    .ldata   (ldata_w)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_FIN: begin
        if (accept) state_nx = trap ? ST_FIN : ST_REQ;
        else        state_nx = ST_IDLE;
      end
      ST_REQ:  state_nx = bus.mem_ack ? ST_FIN : ST_WAIT;
      ST_WAIT: state_nx = (bus.mem_ack || expire) ? ST_FIN : ST_WAIT;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      op_r    <= '0;
      off_r   <= '0;
      wdata_r <= '0;
      addr_r  <= '0;
      we_r    <= 1'b0;
      timer   <= '0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      state <= state_nx;

      if (accept) begin
        op_r    <= start_op;
        off_r   <= Adr[1:0];
        wdata_r <= Wdata;
        addr_r  <= {Adr[ADDR_W-1:2], 2'b00};
        we_r    <= is_store(start_op);
        err_r   <= trap;
      end else if (expire) begin
        err_r <= 1'b1;
      end

      if (state == ST_REQ)       timer <= '0;
      else if (state == ST_WAIT) timer <= timer + 8'd1;

      if (ack_ok && is_load(op_r)) rdata_r <= ldata_w;
    end
  end

  assign busy  = in_bus;
  assign done  = (state == ST_FIN);
  assign err   = err_r;
  assign Rdata = rdata_r;

  // mem_req decodes directly from state so an async reset drops it at once.
  assign bus.mem_req   = in_bus;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_be    = be_w;
  assign bus.mem_wdata = wdata_w;

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;
  import lsu_bus_master_pkg::*;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [31:0] Ins;
  logic [31:0] Adr;
  logic [31:0] Wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] Rdata;

  int checks = 0;
  int errors = 0;

  lsu_bus_master_if #(.ADDR_W(32)) bus ();

  lsu_bus_master #(.TIMEOUT_CYC(16), .ADDR_W(32)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .Ins   (Ins),
    .Adr   (Adr),
    .Wdata (Wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .Rdata (Rdata),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] mwd;
    logic        we;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] adr, input logic [31:0] wd);
    Ins   = {op, 26'h0ABCD};
    Adr   = adr;
    Wdata = wd;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Single transaction: starts from IDLE, ends back in IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    issue(v.op, v.adr, v.wd);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".req"},  32'(bus.mem_req), 32'd1);
    chk({tag, ".be"},   32'(bus.mem_be), 32'(v.be));
    chk({tag, ".addr"}, bus.mem_addr, v.addr);
    chk({tag, ".wdat"}, bus.mem_wdata, v.mwd);
    chk({tag, ".we"},   32'(bus.mem_we), 32'(v.we));
    repeat (v.dly) @(negedge CLK);
    chk({tag, ".hold"}, {27'h0, bus.mem_req, bus.mem_be, done}, {27'h0, 1'b1, v.be, 1'b0});
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = v.rd;
    @(negedge CLK);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    chk({tag, ".done"}, {29'h0, done, err, bus.mem_req}, {29'h0, 1'b1, 1'b0, 1'b0});
    chk({tag, ".busy0"}, 32'(busy), 32'd0);
    chk({tag, ".rdata"}, Rdata, v.rdata);
    @(negedge CLK);
    chk({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic seen_done;
    vec_t v;

    //            op      adr           wd            rd           dly be     addr          mwd           we    rdata
    tbl[0] = '{OP_SW,  32'h100, 32'hDEADBEEF, 32'h0,        3, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0};
    tbl[1] = '{OP_SB,  32'h103, 32'h000000A5, 32'h0,        1, 4'h8, 32'h100, 32'hA5A5A5A5, 1'b1, 32'h0};
    tbl[2] = '{OP_LB,  32'h102, 32'h0,        32'h0080FF00, 2, 4'h4, 32'h100, 32'h0,        1'b0, 32'hFFFFFF80};
    tbl[3] = '{OP_LBU, 32'h102, 32'h0,        32'h0080FF00, 0, 4'h4, 32'h100, 32'h0,        1'b0, 32'h00000080};
    tbl[4] = '{OP_LH,  32'h102, 32'h0,        32'h80011234, 1, 4'hC, 32'h100, 32'h0,        1'b0, 32'hFFFF8001};
    tbl[5] = '{OP_LHU, 32'h102, 32'h0,        32'h80011234, 2, 4'hC, 32'h100, 32'h0,        1'b0, 32'h00008001};
    tbl[6] = '{OP_SH,  32'h102, 32'h1234BEEF, 32'h0,        0, 4'hC, 32'h100, 32'hBEEFBEEF, 1'b1, 32'h00008001};
    tbl[7] = '{OP_LW,  32'h104, 32'h0,        32'hCAFEF00D, 0, 4'hF, 32'h104, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[8] = '{OP_LB,  32'h201, 32'h0,        32'h00007F00, 1, 4'h2, 32'h200, 32'h0,        1'b0, 32'h0000007F};
    tbl[9] = '{OP_LH,  32'h200, 32'h0,        32'h0000FFFE, 3, 4'h3, 32'h200, 32'h0,        1'b0, 32'hFFFFFFFE};

    RST = 1'b0; start = 1'b0; Ins = 32'h0; Adr = 32'h0; Wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge CLK);
    chk("reset.ctl", {27'h0, busy, done, err, bus.mem_req, bus.mem_we}, 32'h0);
    chk("reset.be", 32'(bus.mem_be), 32'h0);
    chk("reset.rdata", Rdata, 32'h0);
    chk("reset.addr", bus.mem_addr, 32'h0);
    chk("reset.wdata", bus.mem_wdata, 32'h0);
    RST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Timeout: no ack; REQ (1 cycle) plus 16 WAIT cycles with mem_req high.
    issue(OP_LW, 32'h108, 32'h0);
    chk("tmo.be", 32'(bus.mem_be), 32'hF);
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      @(negedge CLK);
    end
    chk("tmo.reqcycles", 32'(n), 32'd17);
    chk("tmo.done_err", {30'h0, done, err}, 32'h3);
    chk("tmo.rdata", Rdata, 32'hFFFFFFFE);
    @(negedge CLK);
    chk("tmo.pulse", 32'(done), 32'd0);

    // Non load/store opcode is ignored.
    issue(6'h00, 32'h400, 32'h12345678);
    chk("ign.ctl", {29'h0, busy, bus.mem_req, done}, 32'h0);
    @(negedge CLK);
    chk("ign.done", 32'(done), 32'd0);

    // start while busy is dropped.
    issue(OP_SW, 32'h200, 32'h11111111);
    Ins = {OP_LB, 26'h0}; Adr = 32'h203; Wdata = 32'h0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("bsy.hold", {23'h0, bus.mem_we, bus.mem_be, bus.mem_req, 3'h0}, {23'h0, 1'b1, 4'hF, 1'b1, 3'h0});
    chk("bsy.addr", bus.mem_addr, 32'h200);
    chk("bsy.wdata", bus.mem_wdata, 32'h11111111);
    bus.mem_ack = 1'b1;
    @(negedge CLK);
    bus.mem_ack = 1'b0;
    chk("bsy.done", {30'h0, done, err}, 32'h2);
    @(negedge CLK);
    chk("bsy.idle", {30'h0, bus.mem_req, busy}, 32'h0);
    chk("bsy.rdata", Rdata, 32'hFFFFFFFE);

    // Back-to-back: start accepted during FIN.
    issue(OP_LW, 32'h100, 32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h01020304;
    @(negedge CLK);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    chk("b2b.done1", {30'h0, done, err}, 32'h2);
    chk("b2b.rdata1", Rdata, 32'h01020304);
    issue(OP_LBU, 32'h103, 32'h0);
    chk("b2b.req2", {26'h0, bus.mem_req, busy, bus.mem_be}, {26'h0, 1'b1, 1'b1, 4'h8});
    chk("b2b.nodone", 32'(done), 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h9A000000;
    @(negedge CLK);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    chk("b2b.done2", 32'(done), 32'd1);
    chk("b2b.rdata2", Rdata, 32'h0000009A);
    @(negedge CLK);

    // Misaligned word.
`ifdef LSU_MISALIGN_TRAP_EN
    issue(OP_LW, 32'h101, 32'h0);
    chk("mis.trap", {28'h0, done, err, bus.mem_req, busy}, 32'hC);
    chk("mis.rdata", Rdata, 32'h0000009A);
    @(negedge CLK);
    chk("mis.idle", {30'h0, done, bus.mem_req}, 32'h0);
`else
    v = '{OP_LW, 32'h101, 32'h0, 32'h11223344, 1, 4'hF, 32'h100, 32'h0, 1'b0, 32'h11223344};
    run_vec(v, "mis");
`endif

    // Reset during WAIT: bus request drops immediately, no done pulse.
    issue(OP_LW, 32'h300, 32'h0);
    repeat (2) @(negedge CLK);
    chk("rst.pre", 32'(bus.mem_req), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("rst.async", {29'h0, bus.mem_req, busy, done}, 32'h0);
    chk("rst.rdata", Rdata, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (done) seen_done = 1'b1;
    end
    chk("rst.nodone", 32'(seen_done), 32'd0);
    v = '{OP_LHU, 32'h102, 32'h0, 32'h80011234, 2, 4'hC, 32'h100, 32'h0, 1'b0, 32'h00008001};
    run_vec(v, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
